// File: rtl/v_shift_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : v_shift_scheduler
//  Purpose  : Two-requester round-robin scheduler in front of one shared
//             0..3-bit left-shift stage that is iterated until the requested
//             amount is consumed. Optional macro SHIFT_SAT_EN short-cuts
//             amounts >= WIDTH straight to a zero result.
//  Revision : 1.0  initial release
// ============================================================================
module v_shift_scheduler #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             C,
    input  logic             CLR,
    input  logic             REQ0,
    input  logic             REQ1,
    input  logic [WIDTH-1:0] DI0,
    input  logic [WIDTH-1:0] DI1,
    input  logic [AMT_W-1:0] AMT0,
    input  logic [AMT_W-1:0] AMT1,
    output logic             GNT0,
    output logic             GNT1,
    output logic [WIDTH-1:0] SO,
    output logic             SO_VLD,
    output logic             SO_ID,
    input  logic             SO_ACK,
    output logic             BUSY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [AMT_W-1:0] c_rem_zero = '0;
    localparam logic [AMT_W-1:0] c_max_step = AMT_W'(3);

    state_t           r_state_q;
    state_t           w_state_d;
    logic [WIDTH-1:0] r_acc_q;
    logic [WIDTH-1:0] w_acc_d;
    logic [AMT_W-1:0] r_rem_q;
    logic [AMT_W-1:0] w_rem_d;
    logic             r_id_q;
    logic             w_id_d;
    logic             r_ptr_q;
    logic             w_ptr_d;

    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_gnt_any;
    logic [WIDTH-1:0] w_di_sel;
    logic [AMT_W-1:0] w_amt_sel;
    logic [1:0]       w_sel;
    logic [WIDTH-1:0] w_stage_out;
    logic [AMT_W-1:0] w_rem_next;

    // ------------------------------------------------------------------
    // Arbiter: grants only in IDLE and never while reset is asserted.
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!CLR && (r_state_q == IDLE)) begin
            if (REQ0 && REQ1) begin
                if (r_ptr_q) begin
                    w_gnt1 = 1'b1;
                end else begin
                    w_gnt0 = 1'b1;
                end
            end else if (REQ0) begin
                w_gnt0 = 1'b1;
            end else if (REQ1) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    assign w_gnt_any = w_gnt0 | w_gnt1;
    assign w_di_sel  = w_gnt1 ? DI1  : DI0;
    assign w_amt_sel = w_gnt1 ? AMT1 : AMT0;

    // ------------------------------------------------------------------
    // Shared shift stage: one pass moves the accumulator by min(REM,3).
    // ------------------------------------------------------------------
    assign w_sel = (r_rem_q > c_max_step) ? 2'd3 : r_rem_q[1:0];

    always_comb begin
        w_stage_out = r_acc_q;
        case (w_sel)
            2'd0:    w_stage_out = r_acc_q;
            2'd1:    w_stage_out = r_acc_q << 1;
            2'd2:    w_stage_out = r_acc_q << 2;
            default: w_stage_out = r_acc_q << 3;
        endcase
    end

    assign w_rem_next = r_rem_q - AMT_W'(w_sel);

    // ------------------------------------------------------------------
    // Next-state and datapath update.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        w_acc_d   = r_acc_q;
        w_rem_d   = r_rem_q;
        w_id_d    = r_id_q;
        w_ptr_d   = r_ptr_q;

        case (r_state_q)
            IDLE: begin
                if (w_gnt_any) begin
                    w_id_d  = w_gnt1;
                    // Pointer favours whoever lost this grant.
                    w_ptr_d = w_gnt0;
`ifdef SHIFT_SAT_EN
                    if (32'(w_amt_sel) >= WIDTH) begin
                        w_acc_d   = '0;
                        w_rem_d   = c_rem_zero;
                        w_state_d = DONE;
                    end else begin
                        w_acc_d   = w_di_sel;
                        w_rem_d   = w_amt_sel;
                        w_state_d = (w_amt_sel == c_rem_zero) ? DONE : SHIFT;
                    end
`else
                    w_acc_d   = w_di_sel;
                    w_rem_d   = w_amt_sel;
                    w_state_d = (w_amt_sel == c_rem_zero) ? DONE : SHIFT;
`endif
                end
            end

            SHIFT: begin
                w_acc_d = w_stage_out;
                w_rem_d = w_rem_next;
                if (w_rem_next == c_rem_zero) begin
                    w_state_d = DONE;
                end
            end

            DONE: begin
                if (SO_ACK) begin
                    w_state_d = IDLE;
                end
            end

            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            r_state_q <= IDLE;
            r_acc_q   <= '0;
            r_rem_q   <= '0;
            r_id_q    <= 1'b0;
            r_ptr_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_acc_q   <= w_acc_d;
            r_rem_q   <= w_rem_d;
            r_id_q    <= w_id_d;
            r_ptr_q   <= w_ptr_d;
        end
    end

    // The accumulator is frozen in DONE, so it doubles as the result.
    assign GNT0   = w_gnt0;
    assign GNT1   = w_gnt1;
    assign SO     = r_acc_q;
    assign SO_ID  = r_id_q;
    assign SO_VLD = (r_state_q == DONE);
    assign BUSY   = (r_state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_v_shift_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_v_shift_scheduler
//  Purpose  : Directed self-checking bench for v_shift_scheduler.
//  Revision : 1.0  initial release
// ============================================================================
module tb_v_shift_scheduler;

    logic       C;
    logic       CLR;
    logic       REQ0;
    logic       REQ1;
    logic [7:0] DI0;
    logic [7:0] DI1;
    logic [3:0] AMT0;
    logic [3:0] AMT1;
    logic       GNT0;
    logic       GNT1;
    logic [7:0] SO;
    logic       SO_VLD;
    logic       SO_ID;
    logic       SO_ACK;
    logic       BUSY;

    int total;
    int bad;

    v_shift_scheduler #(.WIDTH(8), .AMT_W(4)) dut (
        .C      (C),
        .CLR    (CLR),
        .REQ0   (REQ0),
        .REQ1   (REQ1),
        .DI0    (DI0),
        .DI1    (DI1),
        .AMT0   (AMT0),
        .AMT1   (AMT1),
        .GNT0   (GNT0),
        .GNT1   (GNT1),
        .SO     (SO),
        .SO_VLD (SO_VLD),
        .SO_ID  (SO_ID),
        .SO_ACK (SO_ACK),
        .BUSY   (BUSY)
    );

    initial begin
        C = 1'b0;
        forever #5 C = ~C;
    end

    task automatic step();
        @(posedge C);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        CLR    = 1'b1;
        REQ0   = 1'b0;
        REQ1   = 1'b0;
        DI0    = 8'h00;
        DI1    = 8'h00;
        AMT0   = 4'd0;
        AMT1   = 4'd0;
        SO_ACK = 1'b0;

        // Reset state, and no grant while reset is held.
        #12;
        chk("rst_so",     32'(SO),     32'h00);
        chk("rst_vld",    32'(SO_VLD), 32'h0);
        chk("rst_id",     32'(SO_ID),  32'h0);
        chk("rst_busy",   32'(BUSY),   32'h0);
        REQ0 = 1'b1;
        #1;
        chk("rst_gnt0",   32'(GNT0),   32'h0);
        step();
        CLR = 1'b0;

        // 0x01 << 7 in passes of 3,3,1.
        DI0  = 8'h01;
        AMT0 = 4'd7;
        #1;
        chk("t1_gnt0", 32'(GNT0), 32'h1);
        chk("t1_gnt1", 32'(GNT1), 32'h0);
        step();
        REQ0 = 1'b0;
        chk("t1_busy", 32'(BUSY),      32'h1);
        chk("t1_sel0", 32'(dut.w_sel), 32'h3);
        step();
        chk("t1_sel1", 32'(dut.w_sel), 32'h3);
        chk("t1_vld1", 32'(SO_VLD),    32'h0);
        step();
        chk("t1_sel2", 32'(dut.w_sel), 32'h1);
        step();
        chk("t1_vld",  32'(SO_VLD), 32'h1);
        chk("t1_so",   32'(SO),     32'h80);
        chk("t1_id",   32'(SO_ID),  32'h0);
        SO_ACK = 1'b1;
        step();
        SO_ACK = 1'b0;
        chk("t1_idle", 32'(BUSY), 32'h0);

        // Zero amount goes straight to DONE.
        REQ1 = 1'b1;
        DI1  = 8'hA5;
        AMT1 = 4'd0;
        #1;
        chk("t3_gnt1", 32'(GNT1), 32'h1);
        step();
        REQ1 = 1'b0;
        chk("t3_vld", 32'(SO_VLD), 32'h1);
        chk("t3_so",  32'(SO),     32'hA5);
        chk("t3_id",  32'(SO_ID),  32'h1);
        SO_ACK = 1'b1;
        step();
        SO_ACK = 1'b0;

        // Amount beyond WIDTH.
        REQ0 = 1'b1;
        DI0  = 8'hFF;
        AMT0 = 4'd15;
        #1;
        chk("t4_gnt0", 32'(GNT0), 32'h1);
        step();
        REQ0 = 1'b0;
`ifdef SHIFT_SAT_EN
        chk("t4_vld",  32'(SO_VLD), 32'h1);
        chk("t4_so",   32'(SO),     32'h00);
`else
        for (int i = 0; i < 5; i++) begin
            chk("t4_shift_vld", 32'(SO_VLD), 32'h0);
            step();
        end
        chk("t4_vld",  32'(SO_VLD), 32'h1);
        chk("t4_so",   32'(SO),     32'h00);
`endif
        SO_ACK = 1'b1;
        step();
        SO_ACK = 1'b0;

        // Held result while a competing request waits.
        REQ0 = 1'b1;
        DI0  = 8'h03;
        AMT0 = 4'd2;
        #1;
        chk("t5_gnt0", 32'(GNT0), 32'h1);
        step();
        REQ0 = 1'b0;
        REQ1 = 1'b1;
        DI1  = 8'h11;
        AMT1 = 4'd1;
        #1;
        chk("t5_shift_gnt1", 32'(GNT1), 32'h0);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("t5_hold_so",   32'(SO),     32'h0C);
            chk("t5_hold_vld",  32'(SO_VLD), 32'h1);
            chk("t5_hold_gnt1", 32'(GNT1),   32'h0);
            step();
        end
        SO_ACK = 1'b1;
        #1;
        chk("t5_ack_gnt1", 32'(GNT1),   32'h0);
        chk("t5_ack_vld",  32'(SO_VLD), 32'h1);
        step();
        SO_ACK = 1'b0;
        #1;
        chk("t5_idle",  32'(BUSY), 32'h0);
        chk("t5_gnt1",  32'(GNT1), 32'h1);
        step();
        REQ1 = 1'b0;
        step();
        chk("t5_so2",  32'(SO),     32'h22);
        chk("t5_id2",  32'(SO_ID),  32'h1);
        chk("t5_vld2", 32'(SO_VLD), 32'h1);
        SO_ACK = 1'b1;
        step();
        SO_ACK = 1'b0;

        // Round-robin alternation from reset.
        CLR = 1'b1;
        step();
        CLR    = 1'b0;
        REQ0   = 1'b1;
        REQ1   = 1'b1;
        DI0    = 8'h01;
        DI1    = 8'h02;
        AMT0   = 4'd1;
        AMT1   = 4'd1;
        SO_ACK = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("t2_gnt0", 32'(GNT0), ((k % 2) == 0) ? 32'h1 : 32'h0);
            chk("t2_gnt1", 32'(GNT1), ((k % 2) == 1) ? 32'h1 : 32'h0);
            step();
            step();
            chk("t2_vld",   32'(SO_VLD), 32'h1);
            chk("t2_id",    32'(SO_ID),  32'(k % 2));
            chk("t2_so",    32'(SO),     ((k % 2) == 0) ? 32'h02 : 32'h04);
            chk("t2_nogn",  32'(GNT0 | GNT1), 32'h0);
            step();
        end
        REQ0   = 1'b0;
        REQ1   = 1'b0;
        SO_ACK = 1'b0;

        // Reset during the second SHIFT pass abandons the operation.
        REQ0 = 1'b1;
        DI0  = 8'h01;
        AMT0 = 4'd9;
        #1;
        chk("t6_gnt0", 32'(GNT0), 32'h1);
        step();
        REQ0 = 1'b0;
        step();
        chk("t6_busy_pre", 32'(BUSY), 32'h1);
        CLR = 1'b1;
        #1;
        chk("t6_so",   32'(SO),     32'h00);
        chk("t6_vld",  32'(SO_VLD), 32'h0);
        chk("t6_busy", 32'(BUSY),   32'h0);
        step();
        CLR = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t6_after_vld",  32'(SO_VLD), 32'h0);
            chk("t6_after_busy", 32'(BUSY),   32'h0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
